mac_csel_adder: RTL and testbench

Parametrised three-stage carry-select adder/subtractor for the MAC datapath, and the successor to the fixed four-block accumulator adder. Block count and width are parameters. It adds subtract mode, optional signed saturation, carry-out and overflow flags, and a valid/ready handshake so the MAC pipeline can stall without losing operands. It sits between the multiplier output and the accumulator register.

---
 rtl/mac_csel_adder.sv | 141 ++++++++++++++
 tb/tb_mac_csel_adder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_csel_adder.sv
// mac_csel_adder: three-stage pipelined carry-select adder/subtractor with optional
// signed saturation, carry/overflow flags and a stall-able valid/ready handshake.
module mac_csel_adder #(
    parameter int INPUT_WIDTH = 32,
    parameter int NUM_BLOCKS  = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [INPUT_WIDTH-1:0] i_adder_a,
    input  logic [INPUT_WIDTH-1:0] i_adder_b,
    input  logic                   i_adder_sub,
    input  logic                   i_adder_sat,
    input  logic                   i_adder_valid,
    output logic                   o_adder_ready,
    output logic [INPUT_WIDTH-1:0] o_adder_val,
    output logic                   o_adder_cout,
    output logic                   o_adder_ovf,
    output logic                   o_adder_valid,
    input  logic                   i_adder_ready
);
    localparam int BLOCK_W = INPUT_WIDTH / NUM_BLOCKS;

    if (((INPUT_WIDTH % NUM_BLOCKS) != 0) || (NUM_BLOCKS < 2)) begin : g_param_check
        $error("mac_csel_adder: INPUT_WIDTH must be a multiple of NUM_BLOCKS and NUM_BLOCKS >= 2");
    end

    // One enable for the whole pipe: bubbles always advance, a held result freezes everything.
    logic en;
    assign en            = ~o_adder_valid | i_adder_ready;
    assign o_adder_ready = en;

    logic [INPUT_WIDTH-1:0] s0_a;
    logic [INPUT_WIDTH-1:0] s0_b;
    logic                   s0_cin;
    logic                   s0_sat;
    logic                   s0_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s0_a     <= '0;
            s0_b     <= '0;
            s0_cin   <= 1'b0;
            s0_sat   <= 1'b0;
            s0_valid <= 1'b0;
        end else if (en) begin
            s0_a     <= i_adder_a;
            s0_b     <= i_adder_sub ? ~i_adder_b : i_adder_b;
            s0_cin   <= i_adder_sub;
            s0_sat   <= i_adder_sat;
            s0_valid <= i_adder_valid;
        end
    end

    logic [NUM_BLOCKS-1:0][BLOCK_W-1:0] p1_sum0;
    logic [NUM_BLOCKS-1:0]              p1_c0;
    logic [NUM_BLOCKS-1:1][BLOCK_W-1:0] p1_sum1;
    logic [NUM_BLOCKS-1:1]              p1_c1;

    // Block 0 absorbs the subtract carry-in; upper blocks precompute both carry-in cases.
    for (genvar k = 0; k < NUM_BLOCKS; k++) begin : g_cand
        logic [BLOCK_W:0] part;
        if (k == 0) begin : g_lsb
            assign part = {1'b0, s0_a[k*BLOCK_W +: BLOCK_W]} + {1'b0, s0_b[k*BLOCK_W +: BLOCK_W]}
                        + {{BLOCK_W{1'b0}}, s0_cin};
        end else begin : g_upper
            assign part       = {1'b0, s0_a[k*BLOCK_W +: BLOCK_W]} + {1'b0, s0_b[k*BLOCK_W +: BLOCK_W]};
            assign p1_sum1[k] = part[BLOCK_W-1:0] + BLOCK_W'(1);
            assign p1_c1[k]   = part[BLOCK_W] | (&part[BLOCK_W-1:0]);
        end
        assign p1_sum0[k] = part[BLOCK_W-1:0];
        assign p1_c0[k]   = part[BLOCK_W];
    end

    logic [NUM_BLOCKS-1:0][BLOCK_W-1:0] s1_sum0;
    logic [NUM_BLOCKS-1:0]              s1_c0;
    logic [NUM_BLOCKS-1:1][BLOCK_W-1:0] s1_sum1;
    logic [NUM_BLOCKS-1:1]              s1_c1;
    logic                               s1_a_msb;
    logic                               s1_b_msb;
    logic                               s1_sat;
    logic                               s1_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_sum0  <= '0;
            s1_c0    <= '0;
            s1_sum1  <= '0;
            s1_c1    <= '0;
            s1_a_msb <= 1'b0;
            s1_b_msb <= 1'b0;
            s1_sat   <= 1'b0;
            s1_valid <= 1'b0;
        end else if (en) begin
            s1_sum0  <= p1_sum0;
            s1_c0    <= p1_c0;
            s1_sum1  <= p1_sum1;
            s1_c1    <= p1_c1;
            s1_a_msb <= s0_a[INPUT_WIDTH-1];
            s1_b_msb <= s0_b[INPUT_WIDTH-1];
            s1_sat   <= s0_sat;
            s1_valid <= s0_valid;
        end
    end

    logic [NUM_BLOCKS-1:0]  carry;
    logic [INPUT_WIDTH-1:0] raw_sum;

    always_comb begin
        carry                = '0;
        raw_sum              = '0;
        carry[0]             = s1_c0[0];
        raw_sum[BLOCK_W-1:0] = s1_sum0[0];
        for (int k = 1; k < NUM_BLOCKS; k++) begin
            raw_sum[k*BLOCK_W +: BLOCK_W] = carry[k-1] ? s1_sum1[k] : s1_sum0[k];
            carry[k]                      = carry[k-1] ? s1_c1[k] : s1_c0[k];
        end
    end

    logic                   sum_ovf;
    logic [INPUT_WIDTH-1:0] sat_val;
    logic [INPUT_WIDTH-1:0] result;

    assign sum_ovf = (s1_a_msb == s1_b_msb) && (raw_sum[INPUT_WIDTH-1] != s1_a_msb);
    assign sat_val = s1_a_msb ? {1'b1, {(INPUT_WIDTH-1){1'b0}}} : {1'b0, {(INPUT_WIDTH-1){1'b1}}};
    assign result  = (s1_sat && sum_ovf) ? sat_val : raw_sum;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_adder_val   <= '0;
            o_adder_cout  <= 1'b0;
            o_adder_ovf   <= 1'b0;
            o_adder_valid <= 1'b0;
        end else if (en) begin
            o_adder_val   <= result;
            o_adder_cout  <= carry[NUM_BLOCKS-1];
            o_adder_ovf   <= sum_ovf;
            o_adder_valid <= s1_valid;
        end
    end

endmodule

// File: tb/tb_mac_csel_adder.sv
// Bench for mac_csel_adder: three widths behind one shared stimulus/scoreboard path.
module tb_mac_csel_adder;
    typedef struct packed {
        logic [63:0] val;
        logic        cout;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic        sat;
        res_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [63:0] a, b;
    logic        sub, sat, in_valid, rdy_in;
    logic [1:0]  sel;
    logic        rand_rdy;
    res_t        cur_exp;
    res_t        sb_q[$];
    vec_t        tbl[11];
    int          n_checks = 0;
    int          n_errors = 0;

    logic        v32, v64, v16, rd32, rd64, rd16;
    logic        ordy32, ordy64, ordy16, ov32, ov64, ov16;
    logic        c32, c64, c16, f32, f64, f16;
    logic [31:0] val32;
    logic [63:0] val64;
    logic [15:0] val16;

    assign v32  = in_valid && (sel == 2'd0);
    assign v64  = in_valid && (sel == 2'd1);
    assign v16  = in_valid && (sel == 2'd2);
    assign rd32 = (sel == 2'd0) ? rdy_in : 1'b1;
    assign rd64 = (sel == 2'd1) ? rdy_in : 1'b1;
    assign rd16 = (sel == 2'd2) ? rdy_in : 1'b1;

    mac_csel_adder #(.INPUT_WIDTH(32), .NUM_BLOCKS(4)) dut32 (
        .i_clk(clk), .i_rst(rst), .i_adder_a(a[31:0]), .i_adder_b(b[31:0]),
        .i_adder_sub(sub), .i_adder_sat(sat), .i_adder_valid(v32), .o_adder_ready(ordy32),
        .o_adder_val(val32), .o_adder_cout(c32), .o_adder_ovf(f32), .o_adder_valid(ov32),
        .i_adder_ready(rd32));

    mac_csel_adder #(.INPUT_WIDTH(64), .NUM_BLOCKS(8)) dut64 (
        .i_clk(clk), .i_rst(rst), .i_adder_a(a), .i_adder_b(b),
        .i_adder_sub(sub), .i_adder_sat(sat), .i_adder_valid(v64), .o_adder_ready(ordy64),
        .o_adder_val(val64), .o_adder_cout(c64), .o_adder_ovf(f64), .o_adder_valid(ov64),
        .i_adder_ready(rd64));

    mac_csel_adder #(.INPUT_WIDTH(16), .NUM_BLOCKS(2)) dut16 (
        .i_clk(clk), .i_rst(rst), .i_adder_a(a[15:0]), .i_adder_b(b[15:0]),
        .i_adder_sub(sub), .i_adder_sat(sat), .i_adder_valid(v16), .o_adder_ready(ordy16),
        .o_adder_val(val16), .o_adder_cout(c16), .o_adder_ovf(f16), .o_adder_valid(ov16),
        .i_adder_ready(rd16));

    res_t obs;
    logic obs_valid, obs_rdy;

    always_comb begin
        obs       = '{val: {32'd0, val32}, cout: c32, ovf: f32};
        obs_valid = ov32;
        obs_rdy   = ordy32;
        if (sel == 2'd1) begin
            obs       = '{val: val64, cout: c64, ovf: f64};
            obs_valid = ov64;
            obs_rdy   = ordy64;
        end else if (sel == 2'd2) begin
            obs       = '{val: {48'd0, val16}, cout: c16, ovf: f16};
            obs_valid = ov16;
            obs_rdy   = ordy16;
        end
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s w_sel=%0d actual=%h required=%h", name, sel, act, req);
        end
    endtask

    // Reference: plain full-width arithmetic, independent of block structure.
    function automatic res_t model(int w, logic [63:0] x, logic [63:0] y, logic s, logic t);
        logic [64:0] mask, yy, sum;
        res_t r;
        mask   = (65'd1 << w) - 65'd1;
        yy     = s ? (~{1'b0, y}) & mask : {1'b0, y} & mask;
        sum    = ({1'b0, x} & mask) + yy + {64'd0, s};
        r.val  = sum[63:0] & mask[63:0];
        r.cout = sum[w];
        r.ovf  = (x[w-1] == yy[w-1]) && (sum[w-1] != x[w-1]);
        if (t && r.ovf) r.val = x[w-1] ? (64'd1 << (w-1)) : ((64'd1 << (w-1)) - 64'd1);
        return r;
    endfunction

    function automatic void build_table(int w);
        logic [63:0] mask, minn, maxp, q3;
        mask = (64'd1 << w) - 64'd1;
        minn = 64'd1 << (w-1);
        maxp = minn - 64'd1;
        q3   = (64'd1 << (w*3/4)) - 64'd1;
        tbl[0]  = '{64'hFF, 64'd1, 1'b0, 1'b0, '{64'h100, 1'b0, 1'b0}};
        tbl[1]  = '{q3,     64'd1, 1'b0, 1'b0, '{q3 + 64'd1, 1'b0, 1'b0}};
        tbl[2]  = '{mask,   64'd1, 1'b0, 1'b0, '{64'd0, 1'b1, 1'b0}};
        tbl[3]  = '{64'd5,  64'd7, 1'b1, 1'b0, '{mask - 64'd1, 1'b0, 1'b0}};
        tbl[4]  = '{maxp,   64'd1, 1'b0, 1'b0, '{minn, 1'b0, 1'b1}};
        tbl[5]  = '{maxp,   64'd1, 1'b0, 1'b1, '{maxp, 1'b0, 1'b1}};
        tbl[6]  = '{minn,   64'd1, 1'b1, 1'b1, '{minn, 1'b1, 1'b1}};
        tbl[7]  = '{minn,   64'd1, 1'b1, 1'b0, '{maxp, 1'b1, 1'b1}};
        tbl[8]  = '{minn,   minn,  1'b0, 1'b1, '{minn, 1'b1, 1'b1}};
        tbl[9]  = '{64'd7,  64'd7, 1'b1, 1'b0, '{64'd0, 1'b1, 1'b0}};
        tbl[10] = '{64'd0,  minn,  1'b1, 1'b1, '{maxp, 1'b0, 1'b1}};
    endfunction

    // Scoreboard: push on accept, pop/compare on output handshake, stability while stalled.
    initial begin : monitor
        res_t prev, e;
        logic prev_stall;
        prev_stall = 1'b0;
        prev       = '0;
        forever begin
            @(negedge clk);
            #1;
            if (prev_stall) begin
                check("stall_valid_hold", 64'(obs_valid), 64'd1);
                check("stall_val_hold", obs.val, prev.val);
                check("stall_flags_hold", {62'd0, obs.cout, obs.ovf}, {62'd0, prev.cout, prev.ovf});
            end
            if (!rst) begin
                check("ready", 64'(obs_rdy), 64'(!obs_valid || rdy_in));
                if (obs_valid && rdy_in) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_out actual=valid val=%h required=no output", obs.val);
                    end else begin
                        e = sb_q.pop_front();
                        check("out_val", obs.val, e.val);
                        check("out_cout", 64'(obs.cout), 64'(e.cout));
                        check("out_ovf", 64'(obs.ovf), 64'(e.ovf));
                    end
                end
                if (in_valid && obs_rdy) sb_q.push_back(cur_exp);
            end
            prev_stall = !rst && obs_valid && !rdy_in;
            prev       = obs;
        end
    end

    always @(negedge clk) if (rand_rdy) rdy_in = 1'($urandom_range(0, 1));

    task automatic send(logic [63:0] x, logic [63:0] y, logic s, logic t, res_t e);
        logic acc;
        a = x; b = y; sub = s; sat = t; cur_exp = e; in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1;
            acc = obs_rdy && !rst;
            @(negedge clk);
            if (acc) return;
        end
        n_checks++;
        n_errors++;
        $display("FAIL send_timeout actual=not accepted required=accepted within 100 cycles");
    endtask

    task automatic drain();
        in_valid = 1'b0;
        rdy_in   = 1'b1;
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    // Empty pipe, downstream ready: a beat accepted at edge N is valid after edge N+2.
    task automatic latency_seq();
        a = 64'hFF; b = 64'd1; sub = 1'b0; sat = 1'b0; in_valid = 1'b1; rdy_in = 1'b1;
        cur_exp = '{64'h100, 1'b0, 1'b0};
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("lat_after_n", 64'(obs_valid), 64'd0);
        @(negedge clk);
        #1 check("lat_after_n1", 64'(obs_valid), 64'd1 - 64'd1);
        @(negedge clk);
        #1 check("lat_after_n2", 64'(obs_valid), 64'd1);
        @(negedge clk);
    endtask

    task automatic run_table(int w, logic [1:0] s);
        sel = s;
        build_table(w);
        for (int i = 0; i < 11; i++) send(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].sat, tbl[i].exp);
        drain();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [63:0] x, y;
        logic        s, t;
        rst = 1'b1; a = '0; b = '0; sub = 1'b0; sat = 1'b0; in_valid = 1'b0;
        rdy_in = 1'b1; sel = 2'd0; rand_rdy = 1'b0; cur_exp = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_val", obs.val, 64'd0);
        check("rst_cout", 64'(obs.cout), 64'd0);
        check("rst_ovf", 64'(obs.ovf), 64'd0);
        check("rst_valid", 64'(obs_valid), 64'd0);
        check("rst_ready", 64'(obs_rdy), 64'd1);
        @(negedge clk);

        latency_seq();
        drain();
        run_table(32, 2'd0);

        // Back-to-back random stream with downstream ready toggling.
        rand_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            x = {$urandom(), $urandom()} & 64'hFFFF_FFFF;
            y = {$urandom(), $urandom()} & 64'hFFFF_FFFF;
            s = 1'($urandom_range(0, 1));
            t = 1'($urandom_range(0, 1));
            send(x, y, s, t, model(32, x, y, s, t));
        end
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        rand_rdy = 1'b0;
        @(negedge clk);
        drain();

        // Reset with three beats in flight and a beat presented during the reset cycle.
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            x = 64'(i * 1000 + 17);
            y = 64'(i * 3 + 5);
            send(x, y, 1'b0, 1'b0, model(32, x, y, 1'b0, 1'b0));
        end
        a = 64'h1234; b = 64'h1; sub = 1'b0; sat = 1'b0; in_valid = 1'b1; rdy_in = 1'b1;
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("mid_rst_val", obs.val, 64'd0);
        check("mid_rst_cout", 64'(obs.cout), 64'd0);
        check("mid_rst_ovf", 64'(obs.ovf), 64'd0);
        check("mid_rst_valid", 64'(obs_valid), 64'd0);
        check("mid_rst_ready", 64'(obs_rdy), 64'd1);
        repeat (6) begin
            @(negedge clk);
            #1 check("no_valid_after_rst", 64'(obs_valid), 64'd0);
        end
        @(negedge clk);
        latency_seq();
        drain();

        run_table(64, 2'd1);
        run_table(16, 2'd2);

        check("final_queue_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
